// File: rtl/sm_regdump.sv
// ============================================================================
// Module   : sm_regdump
// Brief    : Walks the sm_cpu debug port and streams registers 0..LAST_REG
//            out as valid/ready beats, one snapshot per accepted start.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sm_regdump #(
    parameter int LAST_REG = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  snap_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

    logic [1:0]  state_q,     state_d;
    logic [4:0]  reg_addr_q,  reg_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_addr_q,  out_addr_d;
    logic [31:0] out_data_q,  out_data_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic [7:0]  snap_cnt_q,  snap_cnt_d;

    // reg_addr_q doubles as the snapshot index, so the debug port address
    // cannot move while a READ capture is pending.
    always_comb begin
        state_d     = state_q;
        reg_addr_d  = reg_addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        snap_cnt_d  = snap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    reg_addr_d = 5'd0;
                    busy_d     = 1'b1;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                out_data_d  = regData;
                out_addr_d  = reg_addr_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (reg_addr_q == LAST_IDX) begin
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        snap_cnt_d = snap_cnt_q + 8'd1;
                        state_d    = ST_IDLE;
                    end else begin
                        reg_addr_d = reg_addr_q + 5'd1;
                        state_d    = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            reg_addr_q  <= 5'd0;
            out_valid_q <= 1'b0;
            out_addr_q  <= 5'd0;
            out_data_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            snap_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            reg_addr_q  <= reg_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            snap_cnt_q  <= snap_cnt_d;
        end
    end

    assign regAddr   = reg_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign snap_cnt  = snap_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_regdump.sv
// ============================================================================
// Module   : tb_sm_regdump
// Brief    : Scoreboard bench for sm_regdump (LAST_REG=31 and LAST_REG=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sm_regdump;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [7:0]  snap_cnt;

    logic        start2;
    logic [4:0]  reg_addr2;
    logic [31:0] reg_data2;
    logic        out_valid2;
    logic [4:0]  out_addr2;
    logic [31:0] out_data2;
    logic        busy2;
    logic        done2;
    logic [7:0]  snap_cnt2;

    logic [31:0] regfile [32];
    beat_t       sb  [$];
    beat_t       sb2 [$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   beats = 0;
    logic model_busy = 1'b0;
    logic prev_done  = 1'b0;
    logic [7:0] exp_snap = 8'd0;

    always #5 clk = ~clk;

    // Debug port model: entry 0 holds the PC
    assign reg_data  = regfile[reg_addr];
    assign reg_data2 = regfile[reg_addr2];

    sm_regdump #(.LAST_REG(31)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .regAddr(reg_addr), .regData(reg_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done), .snap_cnt(snap_cnt)
    );

    sm_regdump #(.LAST_REG(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .regAddr(reg_addr2), .regData(reg_data2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_addr(out_addr2), .out_data(out_data2),
        .busy(busy2), .done(done2), .snap_cnt(snap_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_regs();
        regfile[0] = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 32'd4;
        for (int i = 1; i < 32; i++) regfile[i] = $urandom;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_vaddr(input logic [4:0] a, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (out_valid && out_addr == a) found = 1'b1;
            else step();
        end
        if (!found) check(tag, 64'd0, 64'd1);
    endtask

    task automatic wait_done(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (done) found = 1'b1;
        end
        if (!found) check(tag, 64'd0, 64'd1);
    endtask

    // Reference of start acceptance and beat order; inputs are stable at negedge
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            sb.delete();
            model_busy = 1'b0;
            exp_snap   = 8'd0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("beat_unexpected", 64'(out_addr), 64'h1_0000);
                end else begin
                    e = sb.pop_front();
                    check("beat_addr", 64'(out_addr), 64'(e.a));
                    check("beat_data", 64'(out_data), 64'(e.d));
                end
                beats++;
            end
            if (done) begin
                check("done_pending", 64'(sb.size()), 64'd0);
                check("done_expected", 64'(model_busy), 64'd1);
                check("done_pulse", 64'(prev_done), 64'd0);
                model_busy = 1'b0;
                exp_snap   = exp_snap + 8'd1;
                check("snap_cnt", 64'(snap_cnt), 64'(exp_snap));
            end
            if (start && !model_busy) begin
                for (int i = 0; i < 32; i++) sb.push_back('{a: 5'(i), d: regfile[i]});
                model_busy = 1'b1;
            end
        end
        prev_done = done;
    end

    initial begin
        logic any_done;
        logic pend;
        logic fin;
        int   ndone;
        int   n;
        int   nb;
        beat_t e;

        rst = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b1;
        randomize_regs();
        step(); step(); step();
        check("rst_regaddr",  64'(reg_addr),  64'd0);
        check("rst_valid",    64'(out_valid), 64'd0);
        check("rst_out_addr", 64'(out_addr),  64'd0);
        check("rst_out_data", 64'(out_data),  64'd0);
        check("rst_busy",     64'(busy),      64'd0);
        check("rst_done",     64'(done),      64'd0);
        check("rst_snap",     64'(snap_cnt),  64'd0);
        rst = 1'b0;
        step();

        // Latency, then abort with reset while stalled in HOLD at addr 7
        pulse_start();
        check("lat_regaddr", 64'(reg_addr),  64'd0);
        check("lat_busy",    64'(busy),      64'd1);
        check("lat_novalid", 64'(out_valid), 64'd0);
        step();
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_addr0", 64'(out_addr),  64'd0);
        check("lat_data0", 64'(out_data),  64'(regfile[0]));
        wait_vaddr(5'd7, "abort_wait7");
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid",   64'(out_valid), 64'd0);
        check("abort_busy",    64'(busy),      64'd0);
        check("abort_regaddr", 64'(reg_addr),  64'd0);
        check("abort_snap",    64'(snap_cnt),  64'd0);
        check("abort_done",    64'(done),      64'd0);
        out_ready = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            any_done = any_done | done | busy;
        end
        check("abort_quiet", 64'(any_done), 64'd0);

        // Reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        step();
        check("rst_prio_idle", 64'(busy), 64'd0);

        // Full snapshot with out_ready tied high
        randomize_regs();
        beats = 0;
        pulse_start();
        step();
        check("full_first_valid", 64'(out_valid), 64'd1);
        n = 1;
        while (!done && n < 200) begin
            step();
            n++;
        end
        // cycles counted inclusively from first out_valid cycle to the done cycle
        check("full_done_latency", 64'(n), 64'd64);
        check("full_beats", 64'(beats), 64'd32);
        check("full_snap", 64'(snap_cnt), 64'd1);

        // Backpressure on beat 3
        randomize_regs();
        beats = 0;
        pulse_start();
        wait_vaddr(5'd3, "stall_wait3");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",   64'(out_valid), 64'd1);
            check("stall_addr",    64'(out_addr),  64'd3);
            check("stall_data",    64'(out_data),  64'(regfile[3]));
            check("stall_regaddr", 64'(reg_addr),  64'd3);
            step();
        end
        out_ready = 1'b1;
        step();
        check("stall_next_regaddr", 64'(reg_addr),  64'd4);
        check("stall_next_gap",     64'(out_valid), 64'd0);
        step();
        check("stall_next_valid", 64'(out_valid), 64'd1);
        check("stall_next_addr",  64'(out_addr),  64'd4);
        check("stall_next_data",  64'(out_data),  64'(regfile[4]));
        wait_done("stall_done");
        check("stall_beats", 64'(beats), 64'd32);
        check("stall_snap", 64'(snap_cnt), 64'd2);

        // Start during a snapshot is ignored
        beats = 0;
        pulse_start();
        wait_vaddr(5'd10, "ign_wait10");
        start = 1'b1;
        step(); step();
        start = 1'b0;
        wait_done("ign_done");
        check("ign_last_addr", 64'(out_addr), 64'd31);
        check("ign_beats", 64'(beats), 64'd32);
        check("ign_snap", 64'(snap_cnt), 64'd3);
        step();
        check("ign_no_restart", 64'(busy), 64'd0);

        // 256 back-to-back snapshots, restart in every done cycle
        start = 1'b1;
        ndone = 0;
        pend  = 1'b0;
        for (int c = 0; c < 20000 && ndone < 256; c++) begin
            step();
            if (pend) begin
                check("b2b_gap", 64'(busy), 64'd1);
                pend = 1'b0;
            end
            if (done) begin
                ndone++;
                if (ndone == 256) start = 1'b0;
                else pend = 1'b1;
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(ndone), 64'd256);
        check("b2b_wrap", 64'(snap_cnt), 64'd3);
        step();
        check("b2b_idle", 64'(busy), 64'd0);

        // LAST_REG=2 instance
        for (int i = 0; i < 3; i++) sb2.push_back('{a: 5'(i), d: regfile[i]});
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        nb  = 0;
        fin = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            step();
            if (out_valid2) begin
                if (sb2.size() == 0) begin
                    check("l2_unexpected", 64'(out_addr2), 64'h1_0000);
                end else begin
                    e = sb2.pop_front();
                    check("l2_addr", 64'(out_addr2), 64'(e.a));
                    check("l2_data", 64'(out_data2), 64'(e.d));
                end
                nb++;
                if (nb == 3) begin
                    step();
                    check("l2_done", 64'(done2), 64'd1);
                    check("l2_snap", 64'(snap_cnt2), 64'd1);
                    fin = 1'b1;
                end
            end
        end
        check("l2_beats", 64'(nb), 64'd3);
        step();
        check("l2_idle", 64'(busy2 | out_valid2 | done2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sm_regdump.md
SM_REGDUMP -- requirements
Module: sm_regdump

Interface
REQ-001 SHALL have parameter: LAST_REG, default 31, highest register index dumped (0..31).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request one register snapshot; sampled each clk.
REQ-005 SHALL have port: regAddr  output  5  register index driven to sm_cpu debug port.
REQ-006 SHALL have port: regData  input  32  combinational read data from sm_cpu debug port (index 0 returns PC).
REQ-007 SHALL have port: out_valid  output  1  output beat valid.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts beat.
REQ-009 SHALL have port: out_addr  output  5  register index of current beat.
REQ-010 SHALL have port: out_data  output  32  captured register value of current beat.
REQ-011 SHALL have port: busy  output  1  snapshot in progress.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after last beat accepted.
REQ-013 SHALL have port: snap_cnt  output  8  count of completed snapshots.

Function
REQ-014 SHALL implement FSM with states IDLE, READ, HOLD; all outputs registered.
REQ-015 SHALL, in IDLE with start=1, load index=0, drive regAddr=0, set busy=1, go READ next cycle.
REQ-016 SHALL ignore start when not in IDLE (no queueing, no restart).
REQ-017 SHALL, in READ, capture regData into out_data and regAddr into out_addr, set out_valid=1, go HOLD.
REQ-018 SHALL hold out_valid, out_addr, out_data stable in HOLD until out_valid&&out_ready.
REQ-019 SHALL, on handshake in HOLD with index<LAST_REG, clear out_valid, increment index, drive regAddr=index+1, go READ.
REQ-020 SHALL, on handshake in HOLD with index==LAST_REG, clear out_valid and busy, pulse done for exactly one cycle, increment snap_cnt, go IDLE.
REQ-021 SHALL wrap snap_cnt 255 -> 0 without flag.
REQ-022 SHALL give latency: start at edge t -> out_valid=1 after edge t+2 (regAddr=0 after t+1); max throughput one beat per 2 cycles.
REQ-023 SHALL produce exactly LAST_REG+1 beats per snapshot, addresses 0..LAST_REG ascending, none skipped or repeated.
REQ-024 SHALL keep regAddr constant throughout READ so captured value corresponds to out_addr.
REQ-025 SHALL accept out_ready asserted while out_valid=0 without effect.
REQ-026 SHALL allow a new start in the cycle done=1 (FSM already IDLE) and begin a new snapshot.

Reset
REQ-027 SHALL, with rst=1 at a rising edge, force state IDLE, index=0, regAddr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, snap_cnt=0.
REQ-028 SHALL abort any snapshot on reset mid-operation; no done pulse, snap_cnt not incremented; rst has priority over start.

Verification
REQ-029 SHALL cover: LAST_REG=31, out_ready tied 1, start pulse -> 32 beats addr 0..31, out_data matches model regData per address, done pulse 64 cycles after first out_valid edge, snap_cnt=1.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles on beat addr 3 -> out_valid, out_addr=3, out_data unchanged for all 5 cycles, regAddr stays 3, then beat 4 follows.
REQ-031 SHALL cover: start asserted during beat 10 -> ignored; snapshot still ends at addr 31, snap_cnt increments by exactly 1.
REQ-032 SHALL cover: rst=1 while in HOLD at addr 7 -> next cycle out_valid=0, busy=0, regAddr=0, snap_cnt unchanged, no done.
REQ-033 SHALL cover: 256 back-to-back snapshots with start asserted on each done cycle -> snap_cnt wraps to 0, no idle cycle gap beyond one.
REQ-034 SHALL cover: LAST_REG=2 -> exactly 3 beats (addr 0,1,2), done after third handshake.
